// File: rtl/output64_pkg.sv
// output64_pkg: shared FSM states and word geometry for output64 (OUTPUT64_CHECKSUM_EN adds CKSUM).
package output64_pkg;
    localparam int BYTES_PER_WORD = 8;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
`ifdef OUTPUT64_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP, CKSUM} state_e;
`else
    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP} state_e;
`endif
endpackage

// File: rtl/output64_hold.sv
// output64_hold: single-entry holding buffer for words arriving mid-transmission.
module output64_hold
    import output64_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              push,
    input  logic              pop,
    output logic [WORD_W-1:0] data_out,
    output logic              full,
    output logic              overflow
);
    logic [WORD_W-1:0] data_q, data_d;
    logic full_q, full_d, ovf_q, ovf_d;
    // a push into a full buffer keeps the held word and only flags the loss
    always_comb begin
        data_d = (push && !full_q) ? data_in : data_q;
        full_d = (push || full_q) && !pop;
        ovf_d  = ovf_q || (push && full_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end
    assign data_out = data_q;
    assign full     = full_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/output64.sv
// output64: serialises 64-bit words MSB byte first into single-byte UART transmit requests.
// Define OUTPUT64_CHECKSUM_EN to append the XOR of the eight bytes as a ninth byte.
module output64
    import output64_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              uart_tx_busy,
    output logic [BYTE_W-1:0] uart_tx_data,
    output logic              uart_tx_en,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [3:0]        byte_idx
);
    localparam logic [3:0] LAST     = 4'(BYTES_PER_WORD);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    state_e state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d, hold_data;
    logic [3:0] idx_q, idx_d;
    logic [7:0] gap_q, gap_d;
    logic hold_full, hold_pop;
`ifdef OUTPUT64_CHECKSUM_EN
    logic [BYTE_W-1:0] ck_q, ck_d;
`endif
    output64_hold u_hold (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .push     (data_in_valid && state_q != IDLE),
        .pop      (hold_pop),
        .data_out (hold_data),
        .full     (hold_full),
        .overflow (overflow)
    );
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        hold_pop = 1'b0;
        done     = 1'b0;
`ifdef OUTPUT64_CHECKSUM_EN
        ck_d     = ck_q;
`endif
        case (state_q)
            IDLE: if (data_in_valid || hold_full) begin
                shift_d  = data_in_valid ? data_in : hold_data;
                hold_pop = !data_in_valid;
`ifdef OUTPUT64_CHECKSUM_EN
                ck_d     = '0;
`endif
                state_d  = SEND;
            end
            SEND: begin
                shift_d = shift_q << BYTE_W;
                idx_d   = idx_q + 4'd1;
`ifdef OUTPUT64_CHECKSUM_EN
                ck_d    = ck_q ^ shift_q[WORD_W-1 -: BYTE_W];
`endif
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (uart_tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!uart_tx_busy) begin
                if (idx_q < LAST) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? SEND : GAP;
                end
`ifdef OUTPUT64_CHECKSUM_EN
                else if (idx_q == LAST) state_d = CKSUM;
`endif
                else begin
                    done    = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                gap_d   = gap_q + 8'd1;
                state_d = (gap_q == GAP_LAST) ? SEND : GAP;
            end
`ifdef OUTPUT64_CHECKSUM_EN
            CKSUM: begin
                shift_d = {ck_q, {(WORD_W-BYTE_W){1'b0}}};
                state_d = SEND;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
`ifdef OUTPUT64_CHECKSUM_EN
            ck_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
`ifdef OUTPUT64_CHECKSUM_EN
            ck_q    <= ck_d;
`endif
        end
    end
    assign uart_tx_en   = state_q == SEND;
    assign uart_tx_data = uart_tx_en ? shift_q[WORD_W-1 -: BYTE_W] : '0;
    assign busy         = state_q != IDLE || hold_full;
    assign byte_idx     = idx_q;
endmodule

// File: tb/tb_output64.sv
// tb_output64: directed stimulus with a word-level scoreboard model of output64.
module tb_output64;
    localparam int GAP  = 4;
    localparam int BUSY = 10;
`ifdef OUTPUT64_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    logic clk = 0, reset = 1;
    logic [63:0] data_in = '0;
    logic data_in_valid = 0, uart_tx_busy = 0;
    logic [7:0] uart_tx_data;
    logic uart_tx_en, busy, done, overflow;
    logic [3:0] byte_idx;
    int total = 0, bad = 0, cyc = 0;

    output64 #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
        .uart_tx_busy(uart_tx_busy), .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en),
        .busy(busy), .done(done), .overflow(overflow), .byte_idx(byte_idx)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // scoreboard: words still owed to the transmitter, as a flat byte stream
    logic [7:0] exp_q[$];
    logic [7:0] log_b[$];
    int log_c[$], done_c[$];
    int pending = 0, cnt = 0, ndone = 0, fall_c = -100, rem = 0;
    logic ovf_m = 0, prev_busy = 0, prev_en = 0;
    wire fall     = prev_busy && !uart_tx_busy;
    wire exp_done = fall && cnt == NB;

    task push_word(input logic [63:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(w[63-8*i -: 8]);
            x ^= w[63-8*i -: 8];
        end
`ifdef OUTPUT64_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pending <= 0; cnt <= 0; ovf_m <= 0; prev_busy <= 0; prev_en <= 0; rem <= 0;
        end else begin
            chk("done", done, exp_done);
            chk("busy", busy, pending != 0);
            chk("byte_idx", byte_idx, cnt);
            chk("overflow", overflow, ovf_m);
            if (uart_tx_en) begin
                chk("en_while_busy", uart_tx_busy, 0);
                chk("en_back_to_back", prev_en, 0);
                chk("en_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("byte", uart_tx_data, exp_q.pop_front());
                if (cnt > 0 && cnt < 8) chk("gap", cyc - fall_c, GAP + 1);
                if (cnt == 8) chk("cksum_latency", cyc - fall_c, 2);
                log_b.push_back(uart_tx_data);
                log_c.push_back(cyc);
            end
            if (fall) fall_c <= cyc;
            if (data_in_valid && pending < 2) push_word(data_in);
            if (data_in_valid && pending >= 2) ovf_m <= 1;
            pending <= pending + ((data_in_valid && pending < 2) ? 1 : 0) - (exp_done ? 1 : 0);
            cnt <= exp_done ? 0 : cnt + (uart_tx_en ? 1 : 0);
            if (exp_done) begin
                ndone <= ndone + 1;
                done_c.push_back(cyc);
            end
            prev_busy <= uart_tx_busy;
            prev_en   <= uart_tx_en;
            rem <= uart_tx_en ? BUSY : (rem > 0 ? rem - 1 : 0);
        end
    end
    always @(posedge clk) uart_tx_busy <= rem != 0;

    int vcyc;
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse(input logic [63:0] w);
        data_in = w;
        data_in_valid = 1;
        vcyc = cyc;
        step();
        data_in_valid = 0;
    endtask
    task automatic wait_done(input int target, input int bound);
        int k = 0;
        while (ndone < target && k < bound) begin step(); k++; end
        chk("done_timeout", ndone >= target, 1);
    endtask
    task automatic wait_bytes(input int target, input int bound);
        int k = 0;
        while (log_b.size() < target && k < bound) begin step(); k++; end
        chk("byte_timeout", log_b.size() >= target, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1 [8];
        int base, nd, dc, k;
        t1 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        step(3);
        reset = 0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_en", uart_tx_en, 0);
        chk("rst_data", uart_tx_data, 0);
        chk("rst_idx", byte_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);

        base = log_b.size(); nd = ndone;
        pulse(64'h0123456789ABCDEF);
        wait_done(nd + 1, 400);
        for (int i = 0; i < 8; i++) chk("t1_byte", log_b[base+i], t1[i]);
        chk("t1_first_en", log_c[base], vcyc + 1);
        chk("t1_spacing", log_c[base+1] - log_c[base], 16);
        chk("t1_count", log_b.size() - base, NB);
        chk("t1_ovf", overflow, 0);
        step(3);

        base = log_b.size(); nd = ndone;
        pulse(64'hDEADBEEFCAFEF00D);
        wait_bytes(base + 3, 200);
        step(2);
        pulse(64'h1122334455667788);
        step(5);
        chk("t2_held_busy", busy, 1);
        pulse(64'hAAAAAAAAAAAAAAAA);
        step();
        chk("t2_ovf", overflow, 1);
        wait_done(nd + 1, 400);
        wait_bytes(base + NB + 1, 50);
        chk("t2_held_latency", log_c[base+NB], done_c[done_c.size()-1] + 2);
        chk("t2_held_byte", log_b[base+NB], 8'h11);
        wait_done(nd + 2, 400);
        step(40);
        chk("t2_drop_count", log_b.size() - base, 2 * NB);
        chk("t2_ovf_sticky", overflow, 1);

        base = log_b.size(); nd = ndone;
        pulse(64'h0F0E0D0C0B0A0908);
        k = 0;
        while (!done && k < 400) begin step(); k++; end
        chk("t3_done_seen", done, 1);
        dc = cyc;
        pulse(64'hA1B2C3D4E5F60718);
        wait_bytes(base + NB + 1, 50);
        chk("t3_latency", log_c[base+NB], dc + 2);
        chk("t3_byte", log_b[base+NB], 8'hA1);
        wait_done(nd + 2, 400);
        step(3);

        base = log_b.size();
        pulse(64'h5555AAAA5555AAAA);
        step(3);
        pulse(64'h7777777777777777);
        wait_bytes(base + 5, 300);
        step(3);
        reset = 1;
        step();
        chk("t5_en", uart_tx_en, 0);
        chk("t5_data", uart_tx_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_idx", byte_idx, 0);
        chk("t5_ovf", overflow, 0);
        reset = 0;
        base = log_b.size(); nd = ndone;
        step(30);
        chk("t5_quiet", log_b.size(), base);
        pulse(64'h8877665544332211);
        wait_done(nd + 1, 400);
        chk("t5_first", log_b[base], 8'h88);
        chk("t5_count", log_b.size() - base, NB);
`ifdef OUTPUT64_CHECKSUM_EN
        step(3);
        base = log_b.size(); nd = ndone;
        pulse(64'hFF00FF00FF00FF00);
        wait_done(nd + 1, 400);
        chk("ck_ninth_a", log_b[base+8], 8'h00);
        chk("ck_idx_a", log_b.size() - base, 9);
        step(3);
        base = log_b.size(); nd = ndone;
        pulse(64'h0100000000000000);
        wait_done(nd + 1, 400);
        chk("ck_ninth_b", log_b[base+8], 8'h01);
`endif
        step(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
